mem_arbiter: RTL and testbench

- Two-port arbiter that shares the single unified instruction/data memory between the processor control unit (port 0) and a second master such as a program loader or DMA engine (port 1).
- It latches one request at a time and drives the memory's address, read/write strobes and bidirectional data bus for a fixed number of cycles.
- It returns a one-cycle acknowledge, plus read data for reads, to the winning requester.
- It sits between CONTROL_UNIT's memory port and the memory model.

---
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified instruction/data memory between two
// masters (port 0 = processor control unit, port 1 = loader/DMA).
// One request is latched at a time and replayed onto the memory for
// MEM_LATENCY cycles, then a one-cycle ACK (plus read data) is returned.
// Conflicting requests are resolved round-robin.
module mem_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 26,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  M0_REQ,
  input  logic                  M0_WE,
  input  logic [ADDR_WIDTH-1:0] M0_ADDR,
  input  logic [DATA_WIDTH-1:0] M0_WDATA,
  output logic [DATA_WIDTH-1:0] M0_RDATA,
  output logic                  M0_ACK,
  input  logic                  M1_REQ,
  input  logic                  M1_WE,
  input  logic [ADDR_WIDTH-1:0] M1_ADDR,
  input  logic [DATA_WIDTH-1:0] M1_WDATA,
  output logic [DATA_WIDTH-1:0] M1_RDATA,
  output logic                  M1_ACK,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  inout  wire  [DATA_WIDTH-1:0] MEM_DATA,
  output logic                  BUSY
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Counter starts at MEM_LATENCY-1 so the strobe spans MEM_LATENCY cycles.
  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  port_q, port_d;     // granted port id
  logic                  we_q, we_d;         // latched direction
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;   // latched write data
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;     // latched address, drives MEM_ADDR
  logic                  rr_q, rr_d;         // 1 = port 1 favoured on conflict
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic                  busy_q, busy_d;

  logic                  req0, req1, pick1, sel_we;

  // Only a clean 1 counts as a request; X/Z from an unconnected master is ignored.
  assign req0   = (M0_REQ === 1'b1);
  assign req1   = (M1_REQ === 1'b1);
  assign pick1  = req1 && (!req0 || rr_q);
  assign sel_we = pick1 ? M1_WE : M0_WE;

  // Next-state and next-output computation for every registered signal.
  always_comb begin
    // NOTE: every output of this block is defaulted first, so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    port_d   = port_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    addr_d   = addr_q;
    rr_d     = rr_q;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = ACCESS;
          port_d  = pick1;
          we_d    = sel_we;
          addr_d  = pick1 ? M1_ADDR  : M0_ADDR;
          wdata_d = pick1 ? M1_WDATA : M0_WDATA;
          cnt_d   = CNT_LOAD;
          rr_d    = ~pick1;
          rd_d    = ~sel_we;
          wr_d    = sel_we;
        end
      end

      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (!we_q) begin
            if (port_q) rdata1_d = MEM_DATA;
            else        rdata0_d = MEM_DATA;
          end
          if (port_q) ack1_d = 1'b1;
          else        ack0_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
          rd_d  = ~we_q;
          wr_d  = we_q;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge CLK or negedge RST) begin
    // NOTE: the data latches are reset along with control so every output is defined from reset.
    if (!RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      addr_q   <= '0;
      rr_q     <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together on the edge.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      port_q   <= port_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      addr_q   <= addr_d;
      rr_q     <= rr_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      busy_q   <= busy_d;
    end
  end

  assign M0_RDATA  = rdata0_q;
  assign M1_RDATA  = rdata1_q;
  assign M0_ACK    = ack0_q;
  assign M1_ACK    = ack1_q;
  assign MEM_ADDR  = addr_q;
  assign MEM_READ  = rd_q;
  assign MEM_WRITE = wr_q;
  assign BUSY      = busy_q;

  // The bus is driven only while the write strobe is up.
  assign MEM_DATA = wr_q ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. Two instances share the
// master-side stimulus: inst A with MEM_LATENCY=1, inst B with MEM_LATENCY=3.
// Each has its own memory model, which also drives a keeper pattern on the
// bus whenever the arbiter is supposed to be high-Z.
module tb_mem_arbiter;
  localparam int DW = 32;
  localparam int AW = 26;
  localparam logic [DW-1:0] KEEP = 32'hA5A5_5A5A;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;

  // instance A outputs
  logic [DW-1:0] m0_rdata_a, m1_rdata_a;
  logic          m0_ack_a, m1_ack_a, mem_read_a, mem_write_a, busy_a;
  logic [AW-1:0] mem_addr_a;
  wire  [DW-1:0] mem_data_a;
  // instance B outputs
  logic [DW-1:0] m0_rdata_b, m1_rdata_b;
  logic          m0_ack_b, m1_ack_b, mem_read_b, mem_write_b, busy_b;
  logic [AW-1:0] mem_addr_b;
  wire  [DW-1:0] mem_data_b;

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(1)) u_dut_a (
    .CLK(CLK), .RST(RST),
    .M0_REQ(m0_req), .M0_WE(m0_we), .M0_ADDR(m0_addr), .M0_WDATA(m0_wdata),
    .M0_RDATA(m0_rdata_a), .M0_ACK(m0_ack_a),
    .M1_REQ(m1_req), .M1_WE(m1_we), .M1_ADDR(m1_addr), .M1_WDATA(m1_wdata),
    .M1_RDATA(m1_rdata_a), .M1_ACK(m1_ack_a),
    .MEM_ADDR(mem_addr_a), .MEM_READ(mem_read_a), .MEM_WRITE(mem_write_a),
    .MEM_DATA(mem_data_a), .BUSY(busy_a)
  );

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(3)) u_dut_b (
    .CLK(CLK), .RST(RST),
    .M0_REQ(m0_req), .M0_WE(m0_we), .M0_ADDR(m0_addr), .M0_WDATA(m0_wdata),
    .M0_RDATA(m0_rdata_b), .M0_ACK(m0_ack_b),
    .M1_REQ(m1_req), .M1_WE(m1_we), .M1_ADDR(m1_addr), .M1_WDATA(m1_wdata),
    .M1_RDATA(m1_rdata_b), .M1_ACK(m1_ack_b),
    .MEM_ADDR(mem_addr_b), .MEM_READ(mem_read_b), .MEM_WRITE(mem_write_b),
    .MEM_DATA(mem_data_b), .BUSY(busy_b)
  );

  // Known memory image restored on every reset.
  function automatic logic [DW-1:0] preset(input int i);
    case (i)
      4:       return 32'hDEAD_BEEF;
      5:       return 32'hCAFE_F00D;
      8:       return 32'h0808_0808;
      default: return 32'h1000_0000 | 32'(i);
    endcase
  endfunction

  logic [DW-1:0] mem_a [64];
  logic [DW-1:0] mem_b [64];
  logic [DW-1:0] drv_a, drv_b;

  always_comb drv_a = mem_read_a ? mem_a[mem_addr_a[5:0]] : KEEP;
  always_comb drv_b = mem_read_b ? mem_b[mem_addr_b[5:0]] : KEEP;
  assign mem_data_a = (!mem_write_a) ? drv_a : {DW{1'bz}};
  assign mem_data_b = (!mem_write_b) ? drv_b : {DW{1'bz}};

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 64; i++) mem_a[i] <= preset(i);
    end else if (mem_write_a) begin
      mem_a[mem_addr_a[5:0]] <= mem_data_a;
    end
  end

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 64; i++) mem_b[i] <= preset(i);
    end else if (mem_write_b) begin
      mem_b[mem_addr_b[5:0]] <= mem_data_b;
    end
  end

  // Observation mux: sel=0 looks at instance A, sel=1 at instance B.
  bit            sel = 1'b0;
  logic [DW-1:0] o_rdata0, o_rdata1, o_bus;
  logic          o_ack0, o_ack1, o_rd, o_wr, o_busy;
  logic [AW-1:0] o_addr;
  always_comb begin
    o_rdata0 = sel ? m0_rdata_b  : m0_rdata_a;
    o_rdata1 = sel ? m1_rdata_b  : m1_rdata_a;
    o_ack0   = sel ? m0_ack_b    : m0_ack_a;
    o_ack1   = sel ? m1_ack_b    : m1_ack_a;
    o_rd     = sel ? mem_read_b  : mem_read_a;
    o_wr     = sel ? mem_write_b : mem_write_a;
    o_busy   = sel ? busy_b      : busy_a;
    o_addr   = sel ? mem_addr_b  : mem_addr_a;
    o_bus    = sel ? mem_data_b  : mem_data_a;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    m0_req = 1'b0; m1_req = 1'b0;
    m0_we  = 1'b0; m1_we  = 1'b0;
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
  endtask

  // One isolated transaction on the selected instance, checked cycle by cycle.
  task automatic run_txn(input bit p, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd);
    int lat;
    lat = sel ? 3 : 1;
    if (p) begin m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wd; end
    else   begin m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wd; end
    tick();
    for (int i = 0; i < lat; i++) begin
      check("strobe_read", o_rd, !we);
      check("strobe_write", o_wr, we);
      check("mem_addr", o_addr, addr);
      if (we) check("bus_wdata", o_bus, wd);
      check("no_early_ack", o_ack0 | o_ack1, 0);
      tick();
    end
    check("ack_winner", p ? o_ack1 : o_ack0, 1);
    check("ack_other", p ? o_ack0 : o_ack1, 0);
    check("done_strobes", {o_rd, o_wr}, 0);
    check("done_bus_z", o_bus, KEEP);
    check("done_busy", o_busy, 1);
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    check("ack_one_cycle", {o_ack0, o_ack1}, 0);
    check("idle_busy", o_busy, 0);
  endtask

  typedef struct {
    bit            sel;
    bit            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_r0;
    logic [DW-1:0] exp_r1;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int acks, bad, rd_cycles, cyc;
    int order [4];
    int ack_cyc [4];
    int n;

    #200_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int acks, bad, rd_cycles, cyc, n;
    int order [4];
    int ack_cyc [4];

    //          sel port we addr    wdata          exp_r0         exp_r1
    vecs[0] = '{0, 0, 0, 26'h04, 32'h0,         32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{0, 1, 0, 26'h05, 32'h0,         32'hDEAD_BEEF, 32'hCAFE_F00D};
    vecs[2] = '{0, 0, 1, 26'h06, 32'h1111_2222, 32'hDEAD_BEEF, 32'hCAFE_F00D};
    vecs[3] = '{0, 1, 0, 26'h06, 32'h0,         32'hDEAD_BEEF, 32'h1111_2222};
    vecs[4] = '{1, 1, 1, 26'h20, 32'h1234_5678, 32'h0,         32'h0};
    vecs[5] = '{1, 1, 0, 26'h20, 32'h0,         32'h0,         32'h1234_5678};
    vecs[6] = '{1, 0, 0, 26'h20, 32'h0,         32'h1234_5678, 32'h1234_5678};
    vecs[7] = '{1, 0, 1, 26'h21, 32'hAABB_CCDD, 32'h1234_5678, 32'h1234_5678};
    vecs[8] = '{1, 0, 0, 26'h21, 32'h0,         32'hAABB_CCDD, 32'h1234_5678};

    // Reset values while RST is held low.
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("rst_strobes", {o_rd, o_wr}, 0);
      check("rst_acks", {o_ack0, o_ack1}, 0);
      check("rst_addr", o_addr, 0);
      check("rst_rdata", {o_rdata0, o_rdata1}, 0);
      check("rst_busy", o_busy, 0);
      check("rst_bus_z", o_bus, KEEP);
    end

    // Table of isolated transactions; reset whenever the instance changes.
    for (int i = 0; i < 9; i++) begin
      if (i == 0 || vecs[i].sel != vecs[i-1].sel) begin
        sel = vecs[i].sel;
        apply_reset();
      end
      run_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      check("rdata0", o_rdata0, vecs[i].exp_r0);
      check("rdata1", o_rdata1, vecs[i].exp_r1);
    end

    // Reset in the middle of an M0 write (inst B, latency 3).
    sel = 1'b1;
    apply_reset();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 26'h10; m0_wdata = 32'h0BAD_F00D;
    tick();
    check("rst_mid_pre_write", o_wr, 1);
    tick();
    RST = 1'b0;
    #1;
    check("rst_mid_write_off", o_wr, 0);
    check("rst_mid_bus_z", o_bus, KEEP);
    check("rst_mid_busy", o_busy, 0);
    check("rst_mid_addr", o_addr, 0);
    m0_req = 1'b0;
    @(posedge CLK);
    #1 RST = 1'b1;
    acks = 0;
    repeat (6) begin
      tick();
      if (o_ack0 || o_ack1) acks++;
    end
    check("rst_mid_no_ack", acks, 0);
    check("rst_mid_idle", {o_busy, o_rd, o_wr}, 0);
    check("rst_mid_rdata0", o_rdata0, 0);

    // Both masters request together and keep requesting: 0,1,0,1.
    apply_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 26'h30;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 26'h31;
    n = 0; cyc = 0; bad = 0;
    while (n < 4 && cyc < 60) begin
      tick();
      cyc++;
      if (o_rd && o_wr) bad++;
      if (o_ack0 && o_ack1) bad++;
      if (o_ack0 && n < 4) begin
        order[n] = 0; ack_cyc[n] = cyc; n++;
        check("simul_rdata0", o_rdata0, 32'h1000_0030);
      end else if (o_ack1 && n < 4) begin
        order[n] = 1; ack_cyc[n] = cyc; n++;
        check("simul_rdata1", o_rdata1, 32'h1000_0031);
      end
    end
    check("simul_ack_count", n, 4);
    check("simul_no_overlap", bad, 0);
    if (n == 4) begin
      check("simul_order", {order[0][0], order[1][0], order[2][0], order[3][0]}, 4'b0101);
      check("simul_ack_cycles",
            {ack_cyc[0][7:0], ack_cyc[1][7:0], ack_cyc[2][7:0], ack_cyc[3][7:0]},
            {8'd4, 8'd9, 8'd14, 8'd19});
    end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (6) tick();

    // M0 hogs the port, M1 asks once: M0, M1, M0 with M1 waiting one transaction.
    apply_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 26'h30;
    tick();
    cyc = 1;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 26'h31;
    n = 0;
    while (n < 3 && cyc < 60) begin
      tick();
      cyc++;
      if (o_ack0 && n < 3) begin
        order[n] = 0; ack_cyc[n] = cyc; n++;
      end else if (o_ack1 && n < 3) begin
        order[n] = 1; ack_cyc[n] = cyc; n++;
        m1_req = 1'b0;
      end
    end
    check("hog_ack_count", n, 3);
    if (n == 3) begin
      check("hog_order", {order[0][0], order[1][0], order[2][0]}, 3'b010);
      check("hog_ack_cycles", {ack_cyc[0][7:0], ack_cyc[1][7:0], ack_cyc[2][7:0]},
            {8'd4, 8'd9, 8'd14});
    end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (6) tick();

    // M0 changes address and drops REQ after grant: latched values win.
    apply_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 26'h08;
    tick();
    m0_addr = 26'h09;
    m0_req  = 1'b0;
    acks = 0; bad = 0; rd_cycles = 0;
    repeat (8) begin
      if (o_rd) begin
        rd_cycles++;
        if (o_addr != 26'h08) bad++;
      end
      if (o_ack0) begin
        acks++;
        check("midchg_rdata0", o_rdata0, 32'h0808_0808);
      end
      tick();
    end
    check("midchg_ack_once", acks, 1);
    check("midchg_addr_held", bad, 0);
    check("midchg_read_cycles", rd_cycles, 3);
    check("midchg_addr_final", o_addr, 26'h08);
    check("midchg_idle", o_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
